// File: rtl/i2c_sched_pkg.sv
// Shared types and sizing for the I2C read scheduler.
// Optional watchdog is enabled with I2C_SCHED_TIMEOUT_EN.
package i2c_sched_pkg;

  localparam int unsigned NREQ               = 4;
  localparam int unsigned ADDR_W             = 7;
  localparam int unsigned DATA_W             = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 200000;
  localparam int unsigned IDX_W              = $clog2(NREQ);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first asserted request searching upward
// from ptr_i+1 with wrap.
module rr_arbiter
  import i2c_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    // Walk from the farthest offset down so the nearest one is written last.
    // NREQ is a power of two, so index wrap is plain truncation.
    for (int off = NREQ; off > 0; off--) begin
      idx = ptr_i + IDX_W'(off);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_read_sched.sv
// Round-robin scheduler issuing 2-byte reads to a shared I2C read engine.
// Define I2C_SCHED_TIMEOUT_EN to compile in the WAIT watchdog.
module i2c_read_sched
  import i2c_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [ADDR_W-1:0]      eng_addr,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic                   eng_nack,
  input  logic [DATA_W-1:0]      eng_data
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               start_q, start_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [ADDR_W-1:0]  addr_arr [NREQ];

  rr_arbiter u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (arb_idx),
    .valid_o  (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             wdog_expired;

  assign wdog_expired = (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          addr_d  = addr_arr[arb_idx];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!eng_busy) begin
          start_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (eng_done) begin
          data_d  = eng_data;
          err_d   = eng_nack;
          state_d = StResp;
        end
`ifdef I2C_SCHED_TIMEOUT_EN
        else if (wdog_expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
`endif
      end
      StResp: begin
        ptr_d   = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(NREQ - 1);
      win_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef I2C_SCHED_TIMEOUT_EN
  // Counts only while staying in WAIT; cleared on every other state.
  always_comb begin
    wdog_d = '0;
    if (state_q == StWait && state_d == StWait) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (state_q == StResp) begin
      gnt[win_q] = 1'b1;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != StIdle);
  assign eng_start = start_q;
  assign eng_addr  = addr_q;

endmodule

// File: tb/tb_i2c_read_sched.sv
// Directed bench for i2c_read_sched; timeout steps run when I2C_SCHED_TIMEOUT_EN is defined.
module tb_i2c_read_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        eng_start;
  logic [6:0]  eng_addr;
  logic        eng_busy;
  logic        eng_done;
  logic        eng_nack;
  logic [15:0] eng_data;

  int checks;
  int errors;

  i2c_read_sched #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack),
    .eng_data  (eng_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'h0);
    chk({tag, "_eng_addr"}, 32'(eng_addr), 32'h0);
  endtask

  // Wait for eng_start, check the address, return data via a done pulse and
  // capture the response; ends in the IDLE cycle after RESP.
  task automatic serve(input string tag, input logic [6:0] exp_addr, input logic [15:0] d,
                       input logic n, output logic [3:0] g, output logic [15:0] rd,
                       output logic re);
    int k;
    k = 0;
    while (eng_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_start"}, 32'(eng_start), 32'h1);
    chk({tag, "_addr"}, 32'(eng_addr), 32'(exp_addr));
    eng_done = 1'b1;
    eng_data = d;
    eng_nack = n;
    tick();
    eng_done = 1'b0;
    eng_nack = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    g  = gnt;
    rd = rsp_data;
    re = rsp_err;
    tick();
  endtask

  logic [3:0]  g;
  logic [15:0] rd;
  logic        re;
  logic        seen;
  int          n;

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_nack = 1'b0;
    eng_data = '0;
    tick();
    tick();
    chk_reset_outputs("reset");

    // Single request from requester 0.
    reset_n        = 1'b1;
    req            = 4'b0001;
    req_addr[6:0]  = 7'h48;
    tick();
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_start_early", 32'(eng_start), 32'h0);
    chk("single_addr", 32'(eng_addr), 32'h48);
    tick();
    chk("single_start", 32'(eng_start), 32'h1);
    req      = 4'b0000;
    eng_done = 1'b1;
    eng_data = 16'h1A2B;
    tick();
    eng_done = 1'b0;
    chk("single_start_pulse", 32'(eng_start), 32'h0);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_data", 32'(rsp_data), 32'h1A2B);
    chk("single_err", 32'(rsp_err), 32'h0);
    tick();
    chk("single_idle_valid", 32'(rsp_valid), 32'h0);
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    chk("single_hold_data", 32'(rsp_data), 32'h1A2B);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // NACK from requester 2.
    req             = 4'b0100;
    req_addr[20:14] = 7'h21;
    serve("nack", 7'h21, 16'hBEEF, 1'b1, g, rd, re);
    req = 4'b0000;
    chk("nack_gnt", 32'(g), 32'h4);
    chk("nack_err", 32'(re), 32'h1);
    chk("nack_data", 32'(rd), 32'hBEEF);

    // Engine busy for 50 cycles in ISSUE (requester 3).
    req             = 4'b1000;
    req_addr[27:21] = 7'h3C;
    eng_busy        = 1'b1;
    tick();
    req  = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (eng_start !== 1'b0) seen = 1'b1;
    end
    chk("busy_no_start", 32'(seen), 32'h0);
    eng_busy = 1'b0;
    tick();
    chk("busy_start_after_fall", 32'(eng_start), 32'h1);
    serve("busy", 7'h3C, 16'h5555, 1'b0, g, rd, re);
    chk("busy_gnt", 32'(g), 32'h8);

    // Fairness with all requesting from ptr=3.
    req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    req      = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      serve("rr", 7'(7'h10 + (i % 4)), 16'(16'h0100 + i), 1'b0, g, rd, re);
      chk("rr_gnt", 32'(g), 32'(4'b0001 << (i % 4)));
      chk("rr_data", 32'(rd), 32'(16'h0100 + i));
    end
    req = 4'b0000;

    // Stray done in IDLE.
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("idle_done_valid", 32'(rsp_valid), 32'h0);
    chk("idle_done_busy", 32'(busy), 32'h0);

    // Reset while in WAIT.
    req            = 4'b0010;
    req_addr[13:7] = 7'h55;
    tick();
    tick();
    chk("midwait_start", 32'(eng_start), 32'h1);
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midwait_reset");
    req = 4'b0000;
    tick();
    reset_n  = 1'b1;
    eng_done = 1'b1;
    eng_data = 16'hDEAD;
    tick();
    eng_done = 1'b0;
    chk("stray_done_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("stray_done_valid2", 32'(rsp_valid), 32'h0);
    chk("stray_done_data", 32'(rsp_data), 32'h0);

`ifdef I2C_SCHED_TIMEOUT_EN
    // Watchdog: no done, response 100 cycles after WAIT entry.
    req           = 4'b0001;
    req_addr[6:0] = 7'h0F;
    tick();
    req = 4'b0000;
    tick();
    chk("to_start", 32'(eng_start), 32'h1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'd100);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_data", 32'(rsp_data), 32'h0);
    chk("to_gnt", 32'(gnt), 32'h1);
    tick();
    eng_done = 1'b1;
    eng_data = 16'h7777;
    tick();
    eng_done = 1'b0;
    chk("late_done_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("late_done_valid2", 32'(rsp_valid), 32'h0);
    chk("late_done_data", 32'(rsp_data), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
